sargantana_icache_ctrl_nbk: RTL and testbench
=============================================

// Module: sargantana_icache_ctrl_nbk
// PURPOSE
// Non-blocking-kill iCache control FSM. It sits between the fetch stage, the iTLB, the tag/data arrays and the L2 IFILL port.
// A kill or flush during a miss no longer stalls fetch until the fill returns. An abandoned fill is counted as stale.
// Its beats are dropped while lookups proceed. Supports multi-beat fills and a ready/valid IFILL request handshake.
// PARAMETERS
// ICACHE_N_WAY  4  number of ways; width of cline_hit_i
// FILL_BEATS    2  response beats per line (1..8); the final beat is flagged by ifill_resp_last_i
// MAX_STALE     2  max abandoned fills in flight (1..7); CNT_W = $clog2(MAX_STALE+1)
// PORTS
// clk_i              in   1      clock
// rstn_i             in   1      asynchronous active-low reset
// cache_enable_i     in   1      cache enable (CSR)
// flush_i            in   1      flush request
// ireq_valid_i       in   1      valid fetch request
// ireq_kill_i        in   1      kill current request
// cline_hit_i        in   N_WAY  per-way tag hit
// mmu_ex_valid_i     in   1      translation exception
// mmu_miss_i         in   1      iTLB miss
// mmu_ptw_valid_i    in   1      PTW response valid
// ifill_req_ready_i  in   1      L2 accepts IFILL request
// ifill_resp_valid_i in   1      fill beat valid
// ifill_resp_last_i  in   1      last beat of a line
// iresp_ready_o      out  1      ctrl accepts a new request
// iresp_valid_o      out  1      response (hit data or exception) valid
// treq_valid_o       out  1      translation re-request
// ifill_req_valid_o  out  1      IFILL request valid
// cmp_enable_o       out  1      tag compare enable
// cache_rd_ena_o     out  1      array read (replay)
// cache_wr_ena_o     out  1      array write, one per accepted beat
// replay_valid_o     out  1      replay strobe
// flush_en_o         out  1      forward flush to arrays
// miss_o             out  1      PMU: miss in progress
// miss_kill_o        out  1      PMU: one-cycle pulse when a fill is abandoned
// stale_cnt_o        out  CNT_W  outstanding abandoned fills
// BEHAVIOUR
// - Terms: hit=|cline_hit_i, kill=flush_i|ireq_kill_i, req=ireq_valid_i. Async reset -> state IDLE, stale_q=0.
// - IDLE: all outputs 0. Next cycle -> READ. Outputs not listed for a state are 0.
// - READ: cmp_enable_o=cache_enable_i.
//   - kill | !req: stay, iresp_ready_o=1.
//   - req & mmu_miss_i: -> TLB_MISS.
//   - req & (hit|ex): iresp_valid_o=iresp_ready_o=1, stay.
//   - req & miss: -> MISS_REQ if stale_q<MAX_STALE, else -> DRAIN.
// - MISS_REQ: ifill_req_valid_o=1, miss_o=1. The request is held until ready.
//   - kill|ex before acceptance: withdraw, -> READ, no stale increment.
//   - ready & kill: stale+1, miss_kill_o=1, -> READ.
//   - ready: -> MISS_WAIT.
// - MISS_WAIT: miss_o=1. In-order responses: while stale_q>0, beats belong to stale fills.
//   - Own beat (stale_q==0): cache_wr_ena_o=!kill. Own last beat & !kill -> REPLAY.
//   - kill|ex with no own last beat this cycle: stale+1, miss_kill_o=1, -> READ.
//   - kill on own last beat: no write, no stale change, -> READ. A killed line never gets its last beat written, so it stays invalid.
// - Stale beats (any state): never written; a stale last beat decrements stale_q. Increment and decrement in the same cycle -> unchanged.
// - Stale beats never block READ hits; there is no ifill_resp_valid_i masking of req.
// - REPLAY: cache_rd_ena_o=replay_valid_o=!kill&!ex, iresp_valid_o=ex, cmp_enable_o=cache_enable_i; -> READ.
// - TLB_MISS:
//   - kill & !ptw: -> KILL_TLB.
//   - ex|kill: -> READ, iresp_valid_o=ex&!kill.
//   - ptw: -> REPLAY_TLB.
// - REPLAY_TLB: treq_valid_o=cache_rd_ena_o=!kill&!mmu_miss_i&!ex, replay_valid_o=1; -> READ.
// - KILL_TLB: wait mmu_ptw_valid_i -> READ.
// - DRAIN: iresp_ready_o=0. -> READ on kill or once stale_q<MAX_STALE; the core re-presents the request.
// - flush_en_o=flush_i in all states except IDLE and KILL_TLB. stale_cnt_o=stale_q.
// - stale_q never exceeds MAX_STALE and never underflows.
// - An unexpected beat (no own fill, stale_q==0) is ignored; a bench assertion flags it.
// - Reset mid-operation: immediate IDLE, stale_q=0. The L2 port is reset with this block.
// TESTING
// 1 READ, req, cline_hit_i=4'b0100 -> iresp_valid_o=iresp_ready_o=1 same cycle; ifill_req_valid_o=0.
// 2 Miss, ready low 2 cycles -> ifill_req_valid_o high 3 cycles; 2 beats -> cache_wr_ena_o 2 cycles; REPLAY with cache_rd_ena_o=1, then READ.
// 3 Kill in MISS_WAIT -> miss_kill_o pulse, stale_cnt_o=1, READ. Hit served during 2 stale beats with cache_wr_ena_o=0; stale_cnt_o=0 after last beat.
// 4 MAX_STALE=2, two killed fills pending, third miss -> DRAIN, ifill_req_valid_o=0; first stale last beat -> READ, stale_cnt_o=1.
// 5 Kill on own last beat -> cache_wr_ena_o=0, stale_cnt_o=0, READ. Stale last beat + new kill same cycle -> stale_cnt_o unchanged.
// 6 mmu_miss_i -> TLB_MISS; flush w/o ptw -> KILL_TLB; ptw -> READ. Separately, ptw in TLB_MISS -> REPLAY_TLB with treq_valid_o=1.

Source files
------------

// File: rtl/sargantana_icache_ctrl_nbk.sv
// rtl/sargantana_icache_ctrl_nbk.sv - non-blocking-kill iCache control FSM
// A kill during a miss abandons the fill; its beats are counted as stale and dropped in order.
module sargantana_icache_ctrl_nbk #(
   parameter  int ICACHE_N_WAY = 4,
   parameter  int FILL_BEATS   = 2,
   parameter  int MAX_STALE    = 2,
   localparam int CNT_W        = $clog2(MAX_STALE + 1)
) (
   input  logic                    clk_i,
   input  logic                    rstn_i,
   input  logic                    cache_enable_i,
   input  logic                    flush_i,
   input  logic                    ireq_valid_i,
   input  logic                    ireq_kill_i,
   input  logic [ICACHE_N_WAY-1:0] cline_hit_i,
   input  logic                    mmu_ex_valid_i,
   input  logic                    mmu_miss_i,
   input  logic                    mmu_ptw_valid_i,
   input  logic                    ifill_req_ready_i,
   input  logic                    ifill_resp_valid_i,
   input  logic                    ifill_resp_last_i,
   output logic                    iresp_ready_o,
   output logic                    iresp_valid_o,
   output logic                    treq_valid_o,
   output logic                    ifill_req_valid_o,
   output logic                    cmp_enable_o,
   output logic                    cache_rd_ena_o,
   output logic                    cache_wr_ena_o,
   output logic                    replay_valid_o,
   output logic                    flush_en_o,
   output logic                    miss_o,
   output logic                    miss_kill_o,
   output logic [CNT_W-1:0]        stale_cnt_o
);

   if (FILL_BEATS < 1 || FILL_BEATS > 8 || MAX_STALE < 1 || MAX_STALE > 7) begin : g_bad_param
      $error("sargantana_icache_ctrl_nbk: parameter out of range");
   end

   typedef enum logic [3:0] {
      S_IDLE, S_READ, S_MISS_REQ, S_MISS_WAIT, S_REPLAY,
      S_TLB_MISS, S_REPLAY_TLB, S_KILL_TLB, S_DRAIN
   } state_t;

   localparam logic [CNT_W-1:0] LP_MAX = CNT_W'(MAX_STALE);

   state_t           r_state;
   state_t           w_next;
   logic [CNT_W-1:0] r_stale;
   logic             w_hit, w_kill, w_ex, w_req;
   logic             w_own_beat, w_stale_dec, w_stale_inc;

   assign w_hit  = |cline_hit_i;
   assign w_kill = flush_i | ireq_kill_i;
   assign w_ex   = mmu_ex_valid_i;
   assign w_req  = ireq_valid_i;

   // Responses are in order: while abandoned fills are outstanding, every beat belongs to them.
   assign w_own_beat  = ifill_resp_valid_i && (r_state == S_MISS_WAIT) && (r_stale == '0);
   assign w_stale_dec = ifill_resp_valid_i && ifill_resp_last_i && (r_stale != '0);

   assign stale_cnt_o = r_stale;

   always_comb begin
      w_next            = r_state;
      w_stale_inc       = 1'b0;
      iresp_ready_o     = 1'b0;
      iresp_valid_o     = 1'b0;
      treq_valid_o      = 1'b0;
      ifill_req_valid_o = 1'b0;
      cmp_enable_o      = 1'b0;
      cache_rd_ena_o    = 1'b0;
      cache_wr_ena_o    = 1'b0;
      replay_valid_o    = 1'b0;
      miss_o            = 1'b0;
      miss_kill_o       = 1'b0;
      case (r_state)
         S_IDLE: w_next = S_READ;
         S_READ: begin
            cmp_enable_o = cache_enable_i;
            if (w_kill || !w_req) begin
               iresp_ready_o = 1'b1;
            end else if (mmu_miss_i) begin
               w_next = S_TLB_MISS;
            end else if (w_hit || w_ex) begin
               iresp_valid_o = 1'b1;
               iresp_ready_o = 1'b1;
            end else begin
               w_next = (r_stale < LP_MAX) ? S_MISS_REQ : S_DRAIN;
            end
         end
         S_MISS_REQ: begin
            ifill_req_valid_o = 1'b1;
            miss_o            = 1'b1;
            if (ifill_req_ready_i && w_kill) begin
               w_stale_inc = 1'b1;
               miss_kill_o = 1'b1;
               w_next      = S_READ;
            end else if (!ifill_req_ready_i && (w_kill || w_ex)) begin
               w_next = S_READ;
            end else if (ifill_req_ready_i) begin
               w_next = S_MISS_WAIT;
            end
         end
         S_MISS_WAIT: begin
            miss_o         = 1'b1;
            cache_wr_ena_o = w_own_beat && !w_kill;
            // A killed own last beat is not written, so the line stays invalid and nothing is left in flight.
            if (w_own_beat && ifill_resp_last_i) begin
               w_next = w_kill ? S_READ : S_REPLAY;
            end else if (w_kill || w_ex) begin
               w_stale_inc = 1'b1;
               miss_kill_o = 1'b1;
               w_next      = S_READ;
            end
         end
         S_REPLAY: begin
            cache_rd_ena_o = !w_kill && !w_ex;
            replay_valid_o = !w_kill && !w_ex;
            iresp_valid_o  = w_ex;
            cmp_enable_o   = cache_enable_i;
            w_next         = S_READ;
         end
         S_TLB_MISS: begin
            if (w_kill && !mmu_ptw_valid_i) begin
               w_next = S_KILL_TLB;
            end else if (w_ex || w_kill) begin
               iresp_valid_o = w_ex && !w_kill;
               w_next        = S_READ;
            end else if (mmu_ptw_valid_i) begin
               w_next = S_REPLAY_TLB;
            end
         end
         S_REPLAY_TLB: begin
            treq_valid_o   = !w_kill && !mmu_miss_i && !w_ex;
            cache_rd_ena_o = !w_kill && !mmu_miss_i && !w_ex;
            replay_valid_o = 1'b1;
            w_next         = S_READ;
         end
         S_KILL_TLB: begin
            if (mmu_ptw_valid_i) w_next = S_READ;
         end
         S_DRAIN: begin
            if (w_kill || r_stale < LP_MAX) w_next = S_READ;
         end
         default: w_next = S_IDLE;
      endcase
      flush_en_o = flush_i && (r_state != S_IDLE) && (r_state != S_KILL_TLB);
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         r_state <= S_IDLE;
         r_stale <= '0;
      end else begin
         r_state <= w_next;
         if (w_stale_inc && !w_stale_dec && r_stale != LP_MAX) begin
            r_stale <= r_stale + CNT_W'(1);
         end else if (w_stale_dec && !w_stale_inc) begin
            r_stale <= r_stale - CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_sargantana_icache_ctrl_nbk.sv
// tb/tb_sargantana_icache_ctrl_nbk.sv - directed and randomized checks for the iCache control FSM
// The random phase models outstanding fills as a queue of abandoned/own entries.
module tb_sargantana_icache_ctrl_nbk;
   localparam int ICACHE_N_WAY = 4;
   localparam int FILL_BEATS   = 2;
   localparam int MAX_STALE    = 2;
   localparam int CNT_W        = $clog2(MAX_STALE + 1);
   localparam int VW           = 11 + CNT_W;

   logic clk_i, rstn_i, cache_enable_i, flush_i, ireq_valid_i, ireq_kill_i;
   logic [ICACHE_N_WAY-1:0] cline_hit_i;
   logic mmu_ex_valid_i, mmu_miss_i, mmu_ptw_valid_i;
   logic ifill_req_ready_i, ifill_resp_valid_i, ifill_resp_last_i;
   logic iresp_ready_o, iresp_valid_o, treq_valid_o, ifill_req_valid_o, cmp_enable_o;
   logic cache_rd_ena_o, cache_wr_ena_o, replay_valid_o, flush_en_o, miss_o, miss_kill_o;
   logic [CNT_W-1:0] stale_cnt_o;

   int errors = 0;
   int checks = 0;

   sargantana_icache_ctrl_nbk #(
      .ICACHE_N_WAY(ICACHE_N_WAY), .FILL_BEATS(FILL_BEATS), .MAX_STALE(MAX_STALE)
   ) dut (
      .clk_i(clk_i), .rstn_i(rstn_i), .cache_enable_i(cache_enable_i), .flush_i(flush_i),
      .ireq_valid_i(ireq_valid_i), .ireq_kill_i(ireq_kill_i), .cline_hit_i(cline_hit_i),
      .mmu_ex_valid_i(mmu_ex_valid_i), .mmu_miss_i(mmu_miss_i), .mmu_ptw_valid_i(mmu_ptw_valid_i),
      .ifill_req_ready_i(ifill_req_ready_i), .ifill_resp_valid_i(ifill_resp_valid_i),
      .ifill_resp_last_i(ifill_resp_last_i), .iresp_ready_o(iresp_ready_o),
      .iresp_valid_o(iresp_valid_o), .treq_valid_o(treq_valid_o),
      .ifill_req_valid_o(ifill_req_valid_o), .cmp_enable_o(cmp_enable_o),
      .cache_rd_ena_o(cache_rd_ena_o), .cache_wr_ena_o(cache_wr_ena_o),
      .replay_valid_o(replay_valid_o), .flush_en_o(flush_en_o), .miss_o(miss_o),
      .miss_kill_o(miss_kill_o), .stale_cnt_o(stale_cnt_o)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   // Reference model state
   typedef enum int {M_IDLE, M_READ, M_MREQ, M_MWAIT, M_REPLAY, M_TLB, M_RTLB, M_KTLB, M_DRAIN} mstate_t;
   mstate_t m_state;
   bit      fq[$];   // in-flight fills in L2 order; 1 = abandoned
   int      bcnt;    // beats already delivered for the front fill

   task automatic step();
      @(negedge clk_i); #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic clear_inputs();
      cache_enable_i = 1'b1; flush_i = 1'b0; ireq_valid_i = 1'b0; ireq_kill_i = 1'b0;
      cline_hit_i = '0; mmu_ex_valid_i = 1'b0; mmu_miss_i = 1'b0; mmu_ptw_valid_i = 1'b0;
      ifill_req_ready_i = 1'b0; ifill_resp_valid_i = 1'b0; ifill_resp_last_i = 1'b0;
   endtask

   task automatic do_reset();
      rstn_i = 1'b0;
      clear_inputs();
      step();
      step();
      rstn_i = 1'b1;
   endtask

   task automatic model_cycle(input bit commit, output logic [VW-1:0] e);
      bit kill, ex, req, hit, front_own, lastb, aband;
      bit rdy, val, trq, frv, cmp, rd, wr, rpl, fl, mis, mk;
      int na, push;
      mstate_t nx;
      kill = flush_i || ireq_kill_i; ex = mmu_ex_valid_i; req = ireq_valid_i; hit = |cline_hit_i;
      na = 0;
      foreach (fq[i]) if (fq[i]) na++;
      front_own = (fq.size() > 0) && !fq[0];
      lastb = ifill_resp_valid_i && ifill_resp_last_i;
      {rdy, val, trq, frv, cmp, rd, wr, rpl, mis, mk, aband} = '0;
      push = 0;
      nx = m_state;
      case (m_state)
         M_IDLE: nx = M_READ;
         M_READ: begin
            cmp = cache_enable_i;
            if (kill || !req) rdy = 1;
            else if (mmu_miss_i) nx = M_TLB;
            else if (hit || ex) begin val = 1; rdy = 1; end
            else nx = (na < MAX_STALE) ? M_MREQ : M_DRAIN;
         end
         M_MREQ: begin
            frv = 1; mis = 1;
            if (ifill_req_ready_i && kill) begin push = 2; mk = 1; nx = M_READ; end
            else if (!ifill_req_ready_i && (kill || ex)) nx = M_READ;
            else if (ifill_req_ready_i) begin push = 1; nx = M_MWAIT; end
         end
         M_MWAIT: begin
            mis = 1;
            if (ifill_resp_valid_i && front_own) wr = !kill;
            if (lastb && front_own) nx = kill ? M_READ : M_REPLAY;
            else if (kill || ex) begin aband = 1; mk = 1; nx = M_READ; end
         end
         M_REPLAY: begin
            rd = !kill && !ex; rpl = !kill && !ex; val = ex; cmp = cache_enable_i; nx = M_READ;
         end
         M_TLB: begin
            if (kill && !mmu_ptw_valid_i) nx = M_KTLB;
            else if (ex || kill) begin val = ex && !kill; nx = M_READ; end
            else if (mmu_ptw_valid_i) nx = M_RTLB;
         end
         M_RTLB: begin
            trq = !kill && !mmu_miss_i && !ex; rd = trq; rpl = 1; nx = M_READ;
         end
         M_KTLB: if (mmu_ptw_valid_i) nx = M_READ;
         M_DRAIN: if (kill || na < MAX_STALE) nx = M_READ;
         default: nx = M_IDLE;
      endcase
      fl = flush_i && (m_state != M_IDLE) && (m_state != M_KTLB);
      e = {rdy, val, trq, frv, cmp, rd, wr, rpl, fl, mis, mk, CNT_W'(na)};
      if (commit) begin
         if (aband) fq[$] = 1'b1;
         if (lastb) void'(fq.pop_front());
         if (push == 1) fq.push_back(1'b0);
         else if (push == 2) fq.push_back(1'b1);
         m_state = nx;
      end
   endtask

   task automatic test_reset();
      rstn_i = 1'b0; clear_inputs();
      flush_i = 1'b1; ireq_valid_i = 1'b1; cline_hit_i = 4'b1111;
      step(); settle();
      checks++; if (iresp_valid_o !== 1'b0) begin errors++; $display("FAIL rst_valid got=%b exp=0", iresp_valid_o); end
      checks++; if (iresp_ready_o !== 1'b0) begin errors++; $display("FAIL rst_ready got=%b exp=0", iresp_ready_o); end
      checks++; if (flush_en_o !== 1'b0) begin errors++; $display("FAIL rst_flush_en got=%b exp=0", flush_en_o); end
      checks++; if (stale_cnt_o !== '0) begin errors++; $display("FAIL rst_stale got=%0d exp=0", stale_cnt_o); end
      rstn_i = 1'b1; clear_inputs(); settle();
      checks++; if (iresp_ready_o !== 1'b0) begin errors++; $display("FAIL idle_ready got=%b exp=0", iresp_ready_o); end
      step();
      checks++; if (iresp_ready_o !== 1'b1) begin errors++; $display("FAIL read_ready got=%b exp=1", iresp_ready_o); end
      checks++; if (cmp_enable_o !== 1'b1) begin errors++; $display("FAIL read_cmp got=%b exp=1", cmp_enable_o); end
   endtask

   task automatic test_hit();
      do_reset(); step();
      ireq_valid_i = 1'b1; cline_hit_i = 4'b0100; settle();
      checks++; if (iresp_valid_o !== 1'b1) begin errors++; $display("FAIL hit_valid got=%b exp=1", iresp_valid_o); end
      checks++; if (iresp_ready_o !== 1'b1) begin errors++; $display("FAIL hit_ready got=%b exp=1", iresp_ready_o); end
      checks++; if (ifill_req_valid_o !== 1'b0) begin errors++; $display("FAIL hit_fillreq got=%b exp=0", ifill_req_valid_o); end
      cache_enable_i = 1'b0; settle();
      checks++; if (cmp_enable_o !== 1'b0) begin errors++; $display("FAIL hit_cmp_dis got=%b exp=0", cmp_enable_o); end
      cache_enable_i = 1'b1;
      step(); cline_hit_i = '0; mmu_ex_valid_i = 1'b1; settle();
      checks++; if (iresp_valid_o !== 1'b1) begin errors++; $display("FAIL ex_valid got=%b exp=1", iresp_valid_o); end
      step(); mmu_ex_valid_i = 1'b0; cline_hit_i = 4'b0010; ireq_kill_i = 1'b1; settle();
      checks++; if ({iresp_valid_o, iresp_ready_o} !== 2'b01) begin errors++; $display("FAIL kill_hit got=%b exp=01", {iresp_valid_o, iresp_ready_o}); end
      step(); ireq_kill_i = 1'b0; ireq_valid_i = 1'b0; ifill_resp_valid_i = 1'b1; ifill_resp_last_i = 1'b1; settle();
      checks++; if (cache_wr_ena_o !== 1'b0) begin errors++; $display("FAIL unexp_beat_wr got=%b exp=0", cache_wr_ena_o); end
      step(); ifill_resp_valid_i = 1'b0; ifill_resp_last_i = 1'b0; settle();
      checks++; if (stale_cnt_o !== '0) begin errors++; $display("FAIL unexp_beat_stale got=%0d exp=0", stale_cnt_o); end
   endtask

   task automatic test_miss_fill();
      int n, w;
      do_reset(); step();
      ireq_valid_i = 1'b1; settle();
      checks++; if ({iresp_valid_o, iresp_ready_o} !== 2'b00) begin errors++; $display("FAIL miss_resp got=%b exp=00", {iresp_valid_o, iresp_ready_o}); end
      step(); ireq_valid_i = 1'b0; n = 0;
      for (int i = 0; i < 3; i++) begin
         ifill_req_ready_i = (i == 2); settle();
         if (ifill_req_valid_o === 1'b1) n++;
         checks++; if (miss_o !== 1'b1) begin errors++; $display("FAIL missreq_miss got=%b exp=1", miss_o); end
         step();
      end
      ifill_req_ready_i = 1'b0; settle();
      checks++; if (n !== 3) begin errors++; $display("FAIL fillreq_cycles got=%0d exp=3", n); end
      checks++; if ({ifill_req_valid_o, miss_o} !== 2'b01) begin errors++; $display("FAIL wait_out got=%b exp=01", {ifill_req_valid_o, miss_o}); end
      step(); ifill_resp_valid_i = 1'b1; w = 0;
      for (int i = 0; i < FILL_BEATS; i++) begin
         ifill_resp_last_i = (i == FILL_BEATS - 1); settle();
         if (cache_wr_ena_o === 1'b1) w++;
         step();
      end
      ifill_resp_valid_i = 1'b0; ifill_resp_last_i = 1'b0; settle();
      checks++; if (w !== FILL_BEATS) begin errors++; $display("FAIL fill_writes got=%0d exp=%0d", w, FILL_BEATS); end
      checks++; if ({cache_rd_ena_o, replay_valid_o, miss_o} !== 3'b110) begin errors++; $display("FAIL replay_out got=%b exp=110", {cache_rd_ena_o, replay_valid_o, miss_o}); end
      step();
      checks++; if (iresp_ready_o !== 1'b1) begin errors++; $display("FAIL post_replay_ready got=%b exp=1", iresp_ready_o); end
   endtask

   task automatic test_kill_stale();
      do_reset(); step();
      ireq_valid_i = 1'b1; step();
      ireq_valid_i = 1'b0; ifill_req_ready_i = 1'b1; step();
      ifill_req_ready_i = 1'b0; ireq_kill_i = 1'b1; settle();
      checks++; if ({miss_kill_o, cache_wr_ena_o} !== 2'b10) begin errors++; $display("FAIL wait_kill got=%b exp=10", {miss_kill_o, cache_wr_ena_o}); end
      step(); ireq_kill_i = 1'b0; settle();
      checks++; if (stale_cnt_o !== CNT_W'(1)) begin errors++; $display("FAIL kill_stale got=%0d exp=1", stale_cnt_o); end
      checks++; if ({miss_kill_o, iresp_ready_o} !== 2'b01) begin errors++; $display("FAIL kill_read got=%b exp=01", {miss_kill_o, iresp_ready_o}); end
      ireq_valid_i = 1'b1; cline_hit_i = 4'b0001; ifill_resp_valid_i = 1'b1;
      for (int i = 0; i < FILL_BEATS; i++) begin
         ifill_resp_last_i = (i == FILL_BEATS - 1); settle();
         checks++; if ({iresp_valid_o, cache_wr_ena_o} !== 2'b10) begin errors++; $display("FAIL stale_hit beat%0d got=%b exp=10", i, {iresp_valid_o, cache_wr_ena_o}); end
         step();
      end
      ifill_resp_valid_i = 1'b0; ifill_resp_last_i = 1'b0; ireq_valid_i = 1'b0; settle();
      checks++; if (stale_cnt_o !== '0) begin errors++; $display("FAIL stale_drained got=%0d exp=0", stale_cnt_o); end
   endtask

   task automatic test_drain();
      do_reset(); step();
      for (int k = 0; k < MAX_STALE; k++) begin
         ireq_valid_i = 1'b1; step();
         ireq_valid_i = 1'b0; ifill_req_ready_i = 1'b1; ireq_kill_i = 1'b1; settle();
         checks++; if (miss_kill_o !== 1'b1) begin errors++; $display("FAIL accept_kill%0d got=%b exp=1", k, miss_kill_o); end
         step(); ifill_req_ready_i = 1'b0; ireq_kill_i = 1'b0;
      end
      settle();
      checks++; if (stale_cnt_o !== CNT_W'(MAX_STALE)) begin errors++; $display("FAIL stale_max got=%0d exp=%0d", stale_cnt_o, MAX_STALE); end
      ireq_valid_i = 1'b1; step(); settle();
      checks++; if ({ifill_req_valid_o, iresp_ready_o, miss_o} !== 3'b000) begin errors++; $display("FAIL drain_out got=%b exp=000", {ifill_req_valid_o, iresp_ready_o, miss_o}); end
      step();
      ifill_resp_valid_i = 1'b1; ifill_resp_last_i = 1'b0; step();
      ifill_resp_last_i = 1'b1; settle();
      checks++; if (iresp_ready_o !== 1'b0) begin errors++; $display("FAIL drain_hold got=%b exp=0", iresp_ready_o); end
      step(); ifill_resp_valid_i = 1'b0; ifill_resp_last_i = 1'b0; ireq_valid_i = 1'b0; settle();
      checks++; if (stale_cnt_o !== CNT_W'(MAX_STALE - 1)) begin errors++; $display("FAIL drain_dec got=%0d exp=%0d", stale_cnt_o, MAX_STALE - 1); end
      step();
      checks++; if (iresp_ready_o !== 1'b1) begin errors++; $display("FAIL drain_exit got=%b exp=1", iresp_ready_o); end
      rstn_i = 1'b0; settle();
      checks++; if ({stale_cnt_o, iresp_ready_o} !== {CNT_W'(0), 1'b0}) begin errors++; $display("FAIL async_rst got=%b exp=0", {stale_cnt_o, iresp_ready_o}); end
      rstn_i = 1'b1;
   endtask

   task automatic test_kill_last();
      do_reset(); step();
      ireq_valid_i = 1'b1; step();
      ireq_valid_i = 1'b0; ifill_req_ready_i = 1'b1; step();
      ifill_req_ready_i = 1'b0; ifill_resp_valid_i = 1'b1; settle();
      checks++; if (cache_wr_ena_o !== 1'b1) begin errors++; $display("FAIL own_beat_wr got=%b exp=1", cache_wr_ena_o); end
      step(); ifill_resp_last_i = 1'b1; ireq_kill_i = 1'b1; settle();
      checks++; if ({cache_wr_ena_o, miss_kill_o} !== 2'b00) begin errors++; $display("FAIL kill_last got=%b exp=00", {cache_wr_ena_o, miss_kill_o}); end
      step(); ifill_resp_valid_i = 1'b0; ifill_resp_last_i = 1'b0; ireq_kill_i = 1'b0; settle();
      checks++; if ({stale_cnt_o, iresp_ready_o, replay_valid_o} !== {CNT_W'(0), 2'b10}) begin errors++; $display("FAIL kill_last_after got=%b exp=0010", {stale_cnt_o, iresp_ready_o, replay_valid_o}); end
      ireq_valid_i = 1'b1; step();
      ireq_valid_i = 1'b0; ifill_req_ready_i = 1'b1; ireq_kill_i = 1'b1; step();
      ireq_kill_i = 1'b0; ifill_req_ready_i = 1'b0; ireq_valid_i = 1'b1; step();
      ireq_valid_i = 1'b0; ifill_req_ready_i = 1'b1; step();
      ifill_req_ready_i = 1'b0; ifill_resp_valid_i = 1'b1; settle();
      checks++; if (cache_wr_ena_o !== 1'b0) begin errors++; $display("FAIL stale_beat_wr got=%b exp=0", cache_wr_ena_o); end
      step(); ifill_resp_last_i = 1'b1; flush_i = 1'b1; settle();
      checks++; if ({miss_kill_o, flush_en_o} !== 2'b11) begin errors++; $display("FAIL inc_dec_kill got=%b exp=11", {miss_kill_o, flush_en_o}); end
      step(); ifill_resp_valid_i = 1'b0; ifill_resp_last_i = 1'b0; flush_i = 1'b0; settle();
      checks++; if (stale_cnt_o !== CNT_W'(1)) begin errors++; $display("FAIL inc_dec_stale got=%0d exp=1", stale_cnt_o); end
   endtask

   task automatic test_tlb();
      do_reset(); step();
      ireq_valid_i = 1'b1; mmu_miss_i = 1'b1; step();
      ireq_valid_i = 1'b0; mmu_miss_i = 1'b0; settle();
      checks++; if ({treq_valid_o, iresp_ready_o} !== 2'b00) begin errors++; $display("FAIL tlb_wait got=%b exp=00", {treq_valid_o, iresp_ready_o}); end
      flush_i = 1'b1; settle();
      checks++; if (flush_en_o !== 1'b1) begin errors++; $display("FAIL tlb_flush_en got=%b exp=1", flush_en_o); end
      step();
      checks++; if ({flush_en_o, iresp_ready_o} !== 2'b00) begin errors++; $display("FAIL killtlb_out got=%b exp=00", {flush_en_o, iresp_ready_o}); end
      flush_i = 1'b0; step();
      checks++; if (iresp_ready_o !== 1'b0) begin errors++; $display("FAIL killtlb_hold got=%b exp=0", iresp_ready_o); end
      mmu_ptw_valid_i = 1'b1; step(); mmu_ptw_valid_i = 1'b0; settle();
      checks++; if (iresp_ready_o !== 1'b1) begin errors++; $display("FAIL killtlb_exit got=%b exp=1", iresp_ready_o); end
      ireq_valid_i = 1'b1; mmu_miss_i = 1'b1; step();
      ireq_valid_i = 1'b0; mmu_miss_i = 1'b0; mmu_ptw_valid_i = 1'b1; step();
      mmu_ptw_valid_i = 1'b0; settle();
      checks++; if ({treq_valid_o, cache_rd_ena_o, replay_valid_o} !== 3'b111) begin errors++; $display("FAIL replay_tlb got=%b exp=111", {treq_valid_o, cache_rd_ena_o, replay_valid_o}); end
      step();
      checks++; if (iresp_ready_o !== 1'b1) begin errors++; $display("FAIL replay_tlb_exit got=%b exp=1", iresp_ready_o); end
      ireq_valid_i = 1'b1; mmu_miss_i = 1'b1; step();
      ireq_valid_i = 1'b0; mmu_miss_i = 1'b0; mmu_ex_valid_i = 1'b1; settle();
      checks++; if (iresp_valid_o !== 1'b1) begin errors++; $display("FAIL tlb_ex got=%b exp=1", iresp_valid_o); end
      step(); mmu_ex_valid_i = 1'b0; settle();
      checks++; if (iresp_ready_o !== 1'b1) begin errors++; $display("FAIL tlb_ex_exit got=%b exp=1", iresp_ready_o); end
   endtask

   task automatic test_random();
      logic [VW-1:0] exp_v, got_v;
      do_reset();
      m_state = M_IDLE; fq.delete(); bcnt = 0;
      for (int c = 0; c < 4000; c++) begin
         rstn_i            = ($urandom_range(0, 599) != 0);
         cache_enable_i    = ($urandom_range(0, 7) != 0);
         flush_i           = ($urandom_range(0, 15) == 0);
         ireq_kill_i       = ($urandom_range(0, 15) == 0);
         ireq_valid_i      = ($urandom_range(0, 3) != 0);
         cline_hit_i       = ($urandom_range(0, 2) == 0) ? ICACHE_N_WAY'(1) << $urandom_range(0, ICACHE_N_WAY - 1) : '0;
         mmu_ex_valid_i    = ($urandom_range(0, 15) == 0);
         mmu_miss_i        = ($urandom_range(0, 7) == 0);
         mmu_ptw_valid_i   = ($urandom_range(0, 3) == 0);
         ifill_req_ready_i = ($urandom_range(0, 1) == 0);
         if (!rstn_i) begin
            m_state = M_IDLE; fq.delete(); bcnt = 0;
            ifill_resp_valid_i = 1'b0;
         end else begin
            ifill_resp_valid_i = (fq.size() > 0) && ($urandom_range(0, 2) == 0);
         end
         ifill_resp_last_i = ifill_resp_valid_i && (bcnt == FILL_BEATS - 1);
         settle();
         model_cycle(rstn_i, exp_v);
         got_v = {iresp_ready_o, iresp_valid_o, treq_valid_o, ifill_req_valid_o, cmp_enable_o,
                  cache_rd_ena_o, cache_wr_ena_o, replay_valid_o, flush_en_o, miss_o, miss_kill_o, stale_cnt_o};
         checks++;
         if (got_v !== exp_v) begin
            errors++;
            $display("FAIL rand cycle %0d outputs got=%b exp=%b", c, got_v, exp_v);
         end
         if (ifill_resp_valid_i) bcnt = ifill_resp_last_i ? 0 : bcnt + 1;
         step();
      end
      rstn_i = 1'b1;
      clear_inputs();
   endtask

   initial begin
      rstn_i = 1'b0;
      clear_inputs();
      test_reset();
      test_hit();
      test_miss_fill();
      test_kill_stale();
      test_drain();
      test_kill_last();
      test_tlb();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
